// File: rtl/isa_pkg.sv
// Shared ISA definitions for the phase-1 control unit: opcodes, IR field
// positions, sequencer state encoding and opcode classification helpers.
package isa_pkg;

    // IR field bit positions
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH0 = 4'd1,
        ST_FETCH1 = 4'd2,
        ST_FETCH2 = 4'd3,
        ST_EXEC3  = 4'd4,
        ST_EXEC4  = 4'd5,
        ST_EXEC5  = 4'd6,
        ST_EXEC6  = 4'd7,
        ST_HALT   = 4'd8
    } state_e;

    // True for opcodes that run through the EXEC4/EXEC5 ALU path
    function automatic logic op_is_alu(input logic [4:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    // MUL/DIV write both LO and HI and need the extra EXEC6 cycle
    function automatic logic op_is_muldiv(input logic [4:0] op);
        logic r;
        case (op)
            OP_MUL, OP_DIV: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    // Unary ops take their second ALU operand from Rb (Rc is unused)
    function automatic logic op_is_unary(input logic [4:0] op);
        logic r;
        case (op)
            OP_NEG, OP_NOT: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// 4-bit register field to one-hot select, gated by an enable.
module reg_sel_decode #(
    parameter int NREGS = 16
) (
    input  logic             en,
    input  logic [3:0]       sel,
    output logic [NREGS-1:0] onehot
);

    // One-hot decode; an out-of-range index yields no select
    always_comb begin
        onehot = {NREGS{1'b0}};
        if (en && (int'(sel) < NREGS)) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = {NREGS{1'b0}};
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Hardwired fetch/execute control unit for the phase-1 DataPath. Moore
// outputs are decoded from the state register and the IR; the timeout
// counter and the sticky error flags are the only other state.
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int NREGS       = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             mem_ready,
    input  logic [31:0]      ir,
    output logic             pc_out,
    output logic             inc_pc,
    output logic             mar_in,
    output logic             z_in,
    output logic             zlo_out,
    output logic             zhi_out,
    output logic             pc_in,
    output logic             mem_read,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             ir_in,
    output logic             y_in,
    output logic             lo_in,
    output logic             hi_in,
    output logic [NREGS-1:0] reg_in,
    output logic [NREGS-1:0] reg_out,
    output logic [4:0]       alu_op,
    output logic             halted,
    output logic             illegal,
    output logic             bus_error
);

    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_r;
    state_e           next_state_s;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic [CNT_W-1:0] tmo_cnt_next_s;
    logic             illegal_r;
    logic             bus_error_r;
    logic             set_illegal_s;
    logic             set_bus_err_s;

    logic [4:0]       opcode_s;
    logic [3:0]       ra_s;
    logic [3:0]       rb_s;
    logic [3:0]       rc_s;
    logic             in_en_s;
    logic             out_en_s;
    logic [3:0]       in_sel_s;
    logic [3:0]       out_sel_s;
    logic             unused_ir_s;

    assign opcode_s    = ir[OP_MSB:OP_LSB];
    assign ra_s        = ir[RA_MSB:RA_LSB];
    assign rb_s        = ir[RB_MSB:RB_LSB];
    assign rc_s        = ir[RC_MSB:RC_LSB];
    assign unused_ir_s = ^ir[RC_LSB-1:0];

    // State, timeout counter and sticky error flags; clear wins over everything
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r     <= ST_IDLE;
            tmo_cnt_r   <= {CNT_W{1'b0}};
            illegal_r   <= 1'b0;
            bus_error_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            tmo_cnt_r   <= tmo_cnt_next_s;
            illegal_r   <= illegal_r | set_illegal_s;
            bus_error_r <= bus_error_r | set_bus_err_s;
        end
    end

    // Next-state logic; the counter only runs while waiting in FETCH1
    always_comb begin
        next_state_s   = state_r;
        tmo_cnt_next_s = {CNT_W{1'b0}};
        set_illegal_s  = 1'b0;
        set_bus_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_FETCH0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH0: next_state_s = ST_FETCH1;
            ST_FETCH1: begin
                if (mem_ready) begin
                    next_state_s = ST_FETCH2;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    set_bus_err_s = 1'b1;
                    next_state_s  = ST_HALT;
                end else begin
                    tmo_cnt_next_s = tmo_cnt_r + CNT_ONE;
                    next_state_s   = ST_FETCH1;
                end
            end
            ST_FETCH2: next_state_s = ST_EXEC3;
            ST_EXEC3: begin
                if (opcode_s == OP_NOP) begin
                    next_state_s = ST_FETCH0;
                end else if (opcode_s == OP_HALT) begin
                    next_state_s = ST_HALT;
                end else if (op_is_alu(opcode_s)) begin
                    next_state_s = ST_EXEC4;
                end else begin
                    set_illegal_s = 1'b1;
                    next_state_s  = ST_HALT;
                end
            end
            ST_EXEC4: next_state_s = ST_EXEC5;
            ST_EXEC5: begin
                if (op_is_muldiv(opcode_s)) begin
                    next_state_s = ST_EXEC6;
                end else begin
                    next_state_s = ST_FETCH0;
                end
            end
            ST_EXEC6: next_state_s = ST_FETCH0;
            ST_HALT:  next_state_s = ST_HALT;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Moore strobe decode; exactly one bus driver per state
    always_comb begin
        pc_out    = 1'b0;
        inc_pc    = 1'b0;
        mar_in    = 1'b0;
        z_in      = 1'b0;
        zlo_out   = 1'b0;
        zhi_out   = 1'b0;
        pc_in     = 1'b0;
        mem_read  = 1'b0;
        mdr_in    = 1'b0;
        mdr_out   = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        lo_in     = 1'b0;
        hi_in     = 1'b0;
        alu_op    = 5'b00000;
        halted    = 1'b0;
        in_en_s   = 1'b0;
        in_sel_s  = ra_s;
        out_en_s  = 1'b0;
        out_sel_s = rb_s;
        case (state_r)
            ST_FETCH0: begin
                pc_out = 1'b1;
                inc_pc = 1'b1;
                mar_in = 1'b1;
                z_in   = 1'b1;
            end
            ST_FETCH1: begin
                zlo_out  = 1'b1;
                pc_in    = 1'b1;
                mem_read = 1'b1;
                mdr_in   = 1'b1;
            end
            ST_FETCH2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            ST_EXEC3: begin
                if (op_is_alu(opcode_s)) begin
                    out_en_s = 1'b1;
                    y_in     = 1'b1;
                end else begin
                    out_en_s = 1'b0;
                end
            end
            ST_EXEC4: begin
                z_in     = 1'b1;
                alu_op   = opcode_s;
                out_en_s = 1'b1;
                if (op_is_unary(opcode_s)) begin
                    out_sel_s = rb_s;
                end else begin
                    out_sel_s = rc_s;
                end
            end
            ST_EXEC5: begin
                zlo_out = 1'b1;
                if (op_is_muldiv(opcode_s)) begin
                    lo_in = 1'b1;
                end else begin
                    in_en_s = 1'b1;
                end
            end
            ST_EXEC6: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    assign illegal   = illegal_r;
    assign bus_error = bus_error_r;

    reg_sel_decode #(.NREGS(NREGS)) u_in_sel (
        .en     (in_en_s),
        .sel    (in_sel_s),
        .onehot (reg_in)
    );

    reg_sel_decode #(.NREGS(NREGS)) u_out_sel (
        .en     (out_en_s),
        .sel    (out_sel_s),
        .onehot (reg_out)
    );

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Hardwired control unit that drives the phase-1 DataPath through fetch and execute for register-register ALU instructions, MUL/DIV into HI/LO, NOP and HALT.
- Replaces hand-sequenced bench control: it emits every per-cycle strobe the DataPath needs (PCout, MARin, Zin, Read, MDRin, IRin, Yin, register in/out selects, ALU opcode).
- Instruction fields are taken from the DataPath IR_VALUE output.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for mem_ready in FETCH1 before bus error.
- NREGS, 16, number of general-purpose registers (one-hot select width).

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous active-high reset
- start  in  1  leave IDLE and begin fetching
- mem_ready  in  1  memory read data valid on Mdatain
- ir  in  32  IR contents: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc
- pc_out, inc_pc, mar_in, z_in, zlo_out, zhi_out, pc_in, mem_read, mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in  out  1 each  DataPath strobes
- reg_in  out  NREGS  one-hot register load enable (R0in..R15in)
- reg_out  out  NREGS  one-hot register bus drive (R0out..R15out)
- alu_op  out  5  ALU opcode
- halted  out  1  in HALT state
- illegal  out  1  sticky: undefined opcode seen
- bus_error  out  1  sticky: mem_ready timeout

Behaviour:
- Reset: state IDLE; all strobes, reg_in, reg_out, alu_op, halted, illegal, bus_error = 0; timeout counter = 0. clear overrides everything, including mid-instruction.
- Moore outputs are decoded from the state register and ir only. Each strobe is held for the whole state. DataPath registers capture on the rising edge that ends the state.
- States and outputs:
  - IDLE: no strobes; start=1 -> FETCH0.
  - FETCH0: pc_out, inc_pc, mar_in, z_in -> FETCH1.
  - FETCH1: zlo_out, pc_in, mem_read, mdr_in.
    - Stays while mem_ready=0; counter increments each waiting cycle.
    - When the counter reaches MEM_TIMEOUT-1 with mem_ready still 0: bus_error=1 -> HALT.
    - mem_ready=1 -> FETCH2, counter cleared.
  - FETCH2: mdr_out, ir_in -> EXEC3.
  - EXEC3: decode ir[31:27].
    - NOP -> FETCH0, no strobes.
    - HALT -> HALT.
    - Undefined -> illegal=1, HALT.
    - Otherwise reg_out[Rb], y_in -> EXEC4.
  - EXEC4: z_in, alu_op=opcode; reg_out[Rc], or reg_out[Rb] for unary NEG/NOT -> EXEC5.
  - EXEC5:
    - MUL/DIV: zlo_out, lo_in -> EXEC6.
    - Otherwise: zlo_out, reg_in[Ra] -> FETCH0.
  - EXEC6: zhi_out, hi_in -> FETCH0.
  - HALT: halted=1, no strobes; leave only via clear. start is ignored.
- Only one of reg_out/pc_out/mdr_out/zlo_out/zhi_out is asserted per state (single bus driver).
- R0 is writable; no hardwired zero.
- Latency with mem_ready=1 at first FETCH1 cycle: R-type 6 cycles, MUL/DIV 7, NOP 4, from FETCH0 entry to next FETCH0.
- alu_op = 0 outside EXEC4.
- A start pulse outside IDLE has no effect.

Decomposition:
- Shared package isa_pkg holds:
  - Opcode constants: ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010, NOP 11010, HALT 11011.
  - IR field bit positions.
  - State encoding.
- One sub-module, reg_sel_decode: 4-bit field to NREGS one-hot with enable. It is instanced twice (in and out selects).

Test Plan:
- clear, start, ir=0x50918000 (AND R1,R2,R3), mem_ready=1 -> strobe sequence FETCH0..EXEC5 over 6 cycles; EXEC3 reg_out=0x0004, EXEC4 reg_out=0x0008 with alu_op=01010, EXEC5 reg_in=0x0002; then FETCH0. In the DataPath system bench with R2=0x12, R3=0x14: R1=0x10.
- ir=0x58918000 (OR R1,R2,R3) back-to-back after AND -> alu_op=01011 in EXEC4; R1=0x16 in system bench.
- ir=0x78118000 (MUL R2,R3) -> EXEC5 asserts zlo_out+lo_in, EXEC6 asserts zhi_out+hi_in; 7 cycles; LO=0x168, HI=0.
- mem_ready held 0 for 3 cycles -> FETCH1 held 4 cycles, PC incremented once. Held 0 for 16 cycles -> bus_error=1, halted=1.
- ir=0xF8000000 -> illegal=1, halted=1, no reg_in asserted. ir=0xD8000000 -> halted=1, illegal=0.
- clear asserted during EXEC4 -> next cycle IDLE with all outputs 0; start restarts at FETCH0.
